// File: rtl/sssp_if.sv
// Host/result bundle for the Dijkstra sequencer: run control, edge memory read
// port and distance readback.
interface sssp_if #(
    parameter int NODE_W  = 4,
    parameter int EDGE_AW = 8,
    parameter int WT_W    = 4,
    parameter int DIST_W  = 8
);
    logic                       start;
    logic [NODE_W-1:0]          n_last;
    logic [EDGE_AW-1:0]         e_count;
    logic                       edge_rd;
    logic [EDGE_AW-1:0]         edge_addr;
    logic [2*NODE_W+WT_W-1:0]   edge_data;
    logic                       busy;
    logic                       done;
    logic [NODE_W-1:0]          dist_idx;
    logic [DIST_W-1:0]          dist_out;
    logic [(2**NODE_W)-1:0]     reached;

    modport slave (
        input  start, n_last, e_count, edge_data, dist_idx,
        output edge_rd, edge_addr, busy, done, dist_out, reached
    );

    modport master (
        output start, n_last, e_count, edge_data, dist_idx,
        input  edge_rd, edge_addr, busy, done, dist_out, reached
    );
endinterface

// File: rtl/sssp_sequencer.sv
// Single-source shortest-path sequencer: linear-scan node selection followed by
// a streamed relaxation pass over the external edge list, node 0 as source.
module sssp_sequencer #(
    parameter int NODE_W  = 4,
    parameter int EDGE_AW = 8,
    parameter int WT_W    = 4,
    parameter int DIST_W  = 8
) (
    input  logic   clk,
    input  logic   reset,
    sssp_if.slave  bus
);
    localparam int NODES = 2 ** NODE_W;
    localparam logic [DIST_W-1:0] INF = {DIST_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_SELECT = 3'd2,
        S_RELAX  = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    state_e                          state_q, state_d;
    logic [NODE_W-1:0]               nlast_q, nlast_d;
    logic [EDGE_AW-1:0]              ecnt_q, ecnt_d;
    logic [NODES-1:0][DIST_W-1:0]    dist_q, dist_d;
    logic [NODES-1:0]                visited_q, visited_d;
    logic [NODE_W-1:0]               sidx_q, sidx_d;
    logic [NODE_W-1:0]               best_q, best_d;
    logic                            best_vld_q, best_vld_d;
    logic [NODE_W-1:0]               u_q, u_d;
    logic [EDGE_AW-1:0]              rcnt_q, rcnt_d;
    logic                            pend_q, pend_d;
    logic                            edge_rd_q, edge_rd_d;
    logic [EDGE_AW-1:0]              edge_addr_q, edge_addr_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;

    logic                            sel_cand_s;
    logic [NODE_W-1:0]               sel_best_s;
    logic                            sel_vld_s;
    logic [NODE_W-1:0]               e_par_s, e_chi_s;
    logic [WT_W-1:0]                 e_wt_s;
    logic [DIST_W:0]                 sum_s;
    logic                            relax_ok_s;

    assign e_par_s = bus.edge_data[NODE_W-1:0];
    assign e_chi_s = bus.edge_data[2*NODE_W-1:NODE_W];
    assign e_wt_s  = bus.edge_data[2*NODE_W+WT_W-1:2*NODE_W];

    // Strict less-than keeps the lowest index on equal distances.
    assign sel_cand_s = !visited_q[sidx_q] && (dist_q[sidx_q] != INF) &&
                        (!best_vld_q || (dist_q[sidx_q] < dist_q[best_q]));
    assign sel_best_s = sel_cand_s ? sidx_q : best_q;
    assign sel_vld_s  = best_vld_q | sel_cand_s;

    assign sum_s = {1'b0, dist_q[u_q]} + {{(DIST_W + 1 - WT_W){1'b0}}, e_wt_s};
    assign relax_ok_s = pend_q && (e_par_s == u_q) && (e_chi_s <= nlast_q) &&
                        !visited_q[e_chi_s] && (sum_s < {1'b0, dist_q[e_chi_s]}) &&
                        (sum_s < {1'b0, INF});

    // Next-state, array update and registered-output computation.
    always_comb begin
        state_d    = state_q;
        nlast_d    = nlast_q;
        ecnt_d     = ecnt_q;
        dist_d     = dist_q;
        visited_d  = visited_q;
        sidx_d     = sidx_q;
        best_d     = best_q;
        best_vld_d = best_vld_q;
        u_d        = u_q;
        rcnt_d     = rcnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    nlast_d = bus.n_last;
                    ecnt_d  = bus.e_count;
                    state_d = S_INIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INIT: begin
                for (int i = 0; i < NODES; i++) begin
                    dist_d[i] = INF;
                end
                dist_d[0]  = {DIST_W{1'b0}};
                visited_d  = {NODES{1'b0}};
                sidx_d     = {NODE_W{1'b0}};
                best_vld_d = 1'b0;
                state_d    = S_SELECT;
            end
            S_SELECT: begin
                best_d     = sel_best_s;
                best_vld_d = sel_vld_s;
                if (sidx_q == nlast_q) begin
                    sidx_d     = {NODE_W{1'b0}};
                    best_vld_d = 1'b0;
                    if (sel_vld_s) begin
                        visited_d[sel_best_s] = 1'b1;
                        u_d    = sel_best_s;
                        rcnt_d = {EDGE_AW{1'b0}};
                        if (ecnt_q != {EDGE_AW{1'b0}}) begin
                            state_d = S_RELAX;
                        end else begin
                            state_d = S_SELECT;
                        end
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    sidx_d = sidx_q + NODE_W'(1);
                end
            end
            S_RELAX: begin
                if (relax_ok_s) begin
                    dist_d[e_chi_s] = sum_s[DIST_W-1:0];
                end else begin
                    dist_d = dist_q;
                end
                // The final cycle only consumes the word read in the previous cycle.
                if (rcnt_q == ecnt_q) begin
                    sidx_d     = {NODE_W{1'b0}};
                    best_vld_d = 1'b0;
                    state_d    = S_SELECT;
                end else begin
                    rcnt_d = rcnt_q + EDGE_AW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        edge_rd_d   = (state_d == S_RELAX) && (rcnt_d < ecnt_q);
        edge_addr_d = edge_rd_d ? rcnt_d : {EDGE_AW{1'b0}};
        pend_d      = edge_rd_q;
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            nlast_q     <= {NODE_W{1'b0}};
            ecnt_q      <= {EDGE_AW{1'b0}};
            dist_q      <= {NODES{INF}};
            visited_q   <= {NODES{1'b0}};
            sidx_q      <= {NODE_W{1'b0}};
            best_q      <= {NODE_W{1'b0}};
            best_vld_q  <= 1'b0;
            u_q         <= {NODE_W{1'b0}};
            rcnt_q      <= {EDGE_AW{1'b0}};
            pend_q      <= 1'b0;
            edge_rd_q   <= 1'b0;
            edge_addr_q <= {EDGE_AW{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            nlast_q     <= nlast_d;
            ecnt_q      <= ecnt_d;
            dist_q      <= dist_d;
            visited_q   <= visited_d;
            sidx_q      <= sidx_d;
            best_q      <= best_d;
            best_vld_q  <= best_vld_d;
            u_q         <= u_d;
            rcnt_q      <= rcnt_d;
            pend_q      <= pend_d;
            edge_rd_q   <= edge_rd_d;
            edge_addr_q <= edge_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.edge_rd   = edge_rd_q;
    assign bus.edge_addr = edge_addr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.reached   = visited_q;
    assign bus.dist_out  = dist_q[bus.dist_idx];
endmodule
